if_id_stage: RTL

- Fetch/decode front end of the 16-bit CPU; sits directly upstream of the register file and drives its rs/rt/rd/reg_write inputs.
- Owns the PC and the single-request instruction-memory handshake.
- Holds the IF/ID pipeline register and decodes the held instruction into register addresses, immediate and control.
- Supports stall (hold) and redirect (branch/jump flush) from downstream stages.

---
 rtl/if_id_stage.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - fetch / IF-ID register / decode front end of the 16-bit CPU
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   stall                   downstream hold: IF/ID keeps its contents
//   redirect, redirect_pc   flush and restart fetch at redirect_pc (beats stall)
//   imem_req, imem_addr     single outstanding fetch request, stable until imem_ready
//   imem_rdata, imem_ready  returned instruction word and completion strobe
//   id_valid, id_inst,      IF/ID register: live flag, instruction, its address + 1
//   id_pc_plus1
//   rs, rt, rd, opcode,     combinational decode of id_inst
//   funct, imm_sext, jaddr,
//   reg_write, illegal
module if_id_stage #(
    parameter int                  inst_SIZE = 16,
    parameter int                  PC_SIZE   = 13,
    parameter logic [PC_SIZE-1:0]  RESET_PC  = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [PC_SIZE-1:0]    redirect_pc,
    output logic                  imem_req,
    output logic [PC_SIZE-1:0]    imem_addr,
    input  logic [inst_SIZE-1:0]  imem_rdata,
    input  logic                  imem_ready,
    output logic                  id_valid,
    output logic [inst_SIZE-1:0]  id_inst,
    output logic [PC_SIZE-1:0]    id_pc_plus1,
    output logic [2:0]            rs,
    output logic [2:0]            rt,
    output logic [2:0]            rd,
    output logic [3:0]            opcode,
    output logic [2:0]            funct,
    output logic [inst_SIZE-1:0]  imm_sext,
    output logic [11:0]           jaddr,
    output logic                  reg_write,
    output logic                  illegal
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [PC_SIZE-1:0] PC_ONE = {{(PC_SIZE-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [PC_SIZE-1:0]     pc_q, pc_d;
    logic [PC_SIZE-1:0]     drain_addr_q, drain_addr_d;
    logic                   id_valid_q, id_valid_d;
    logic [inst_SIZE-1:0]   id_inst_q, id_inst_d;
    logic [PC_SIZE-1:0]     id_pc1_q, id_pc1_d;
    logic [inst_SIZE-1:0]   pend_inst_q, pend_inst_d;
    logic [PC_SIZE-1:0]     pend_pc1_q, pend_pc1_d;

    logic                   req_active;
    logic [PC_SIZE-1:0]     pc_inc;

    // A request is on the bus in every state except S_HOLD; reset_n gates it
    // so nothing is requested while reset is held.
    assign req_active = (state_q != S_HOLD);
    assign imem_req   = reset_n & req_active;
    // While draining, the abandoned request keeps its address even though pc
    // already points at the redirect target.
    assign imem_addr  = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    assign pc_inc     = pc_q + PC_ONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            id_valid_q   <= 1'b0;
            id_inst_q    <= '0;
            id_pc1_q     <= '0;
            pend_inst_q  <= '0;
            pend_pc1_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            id_valid_q   <= id_valid_d;
            id_inst_q    <= id_inst_d;
            id_pc1_q     <= id_pc1_d;
            pend_inst_q  <= pend_inst_d;
            pend_pc1_q   <= pend_pc1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        id_valid_d   = id_valid_q;
        id_inst_d    = id_inst_q;
        id_pc1_d     = id_pc1_q;
        pend_inst_d  = pend_inst_q;
        pend_pc1_d   = pend_pc1_q;

        if (redirect) begin
            pc_d        = redirect_pc;
            id_valid_d  = 1'b0;
            pend_inst_d = '0;
            pend_pc1_d  = '0;
            if (req_active && !imem_ready) begin
                // Outstanding fetch cannot be aborted: wait it out at the old
                // address. In S_DRAIN imem_addr already equals drain_addr_q.
                state_d      = S_DRAIN;
                drain_addr_d = imem_addr;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_ready) begin
                        pc_d = pc_inc;
                        if (!stall) begin
                            id_valid_d = 1'b1;
                            id_inst_d  = imem_rdata;
                            id_pc1_d   = pc_inc;
                        end else begin
                            pend_inst_d = imem_rdata;
                            pend_pc1_d  = pc_inc;
                            state_d     = S_HOLD;
                        end
                    end else if (!stall) begin
                        id_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        id_valid_d = 1'b1;
                        id_inst_d  = pend_inst_q;
                        id_pc1_d   = pend_pc1_q;
                        state_d    = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (!stall) begin
                        id_valid_d = 1'b0;
                    end
                    if (imem_ready) begin
                        state_d = S_REQ;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    assign id_valid    = id_valid_q;
    assign id_inst     = id_inst_q;
    assign id_pc_plus1 = id_pc1_q;

    assign opcode   = id_inst_q[15:12];
    assign rs       = id_inst_q[11:9];
    assign rt       = id_inst_q[8:6];
    assign funct    = id_inst_q[2:0];
    assign jaddr    = id_inst_q[11:0];
    assign imm_sext = {{(inst_SIZE-6){id_inst_q[5]}}, id_inst_q[5:0]};

    always_comb begin
        rd        = id_inst_q[5:3];
        reg_write = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            4'b0000: reg_write = 1'b1;
            4'b0001, 4'b0010, 4'b0011, 4'b0100: begin
                rd        = id_inst_q[8:6];
                reg_write = 1'b1;
            end
            4'b0101, 4'b0110, 4'b0111, 4'b1000: reg_write = 1'b0;
            4'b1001: begin
                rd        = 3'd7;
                reg_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        reg_write = reg_write & id_valid_q;
        illegal   = illegal & id_valid_q;
    end

endmodule
